ram_dp_clr: RTL and testbench

RAM_DP_CLR -- requirements
Module: ram_dp_clr

---
 rtl/ram_pkg.sv | 14 +
 rtl/ram_clr_ctrl.sv | 57 +++++
 rtl/ram_dp_clr.sv | 125 ++++++++++++
 tb/tb_ram_dp_clr.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the dual-port clearable RAM.
package ram_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } ram_state_t;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/ram_clr_ctrl.sv
// Clear-sweep controller: walks every address once after reset or a clr request.
//   state | meaning
//   IDLE  | normal read/write service, waiting for clr
//   CLEAR | zeroing mem[cnt] each cycle, ports blocked
module ram_clr_ctrl
    import ram_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    ram_state_t        state;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                CLEAR: begin
                    // clr is deliberately not looked at here: no restart or extension
                    if (cnt == LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy     = (state == CLEAR);
    assign clr_we   = busy;
    assign clr_addr = cnt;

endmodule

// File: rtl/ram_dp_clr.sv
// Simple dual-port RAM with byte enables, write-first read and a full-array clear sweep.
// Define RAM_PARITY_EN to add per-byte even parity with par_inv / parity_err ports.
module ram_dp_clr
    import ram_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 32,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_be,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              clr,
    output logic              busy
`ifdef RAM_PARITY_EN
    ,
    input  logic              par_inv,
    output logic              parity_err
`endif
);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    ram_clr_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_in, rd_in, wr_ok, rd_ok, same_addr;
    logic [DATA_W-1:0] rd_word;

    // Addresses past DEPTH only exist when DEPTH is not a power of two.
    assign wr_in     = ({1'b0, wr_addr} < DEPTH_X);
    assign rd_in     = ({1'b0, rd_addr} < DEPTH_X);
    assign wr_ok     = wr_en && !busy && wr_in;
    assign rd_ok     = rd_en && !busy;
    assign same_addr = wr_ok && (wr_addr == rd_addr);

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Write-first: enabled bytes of a colliding write bypass the array.
    always_comb begin
        rd_word = '0;
        if (rd_in) begin
            rd_word = mem[rd_addr];
            if (same_addr) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            if (rd_ok) rd_data <= rd_word;
        end
    end

`ifdef RAM_PARITY_EN
    logic [BE_W-1:0] par_mem [DEPTH];
    logic [BE_W-1:0] rd_par;
    logic            rd_perr;

    always_ff @(posedge clk) begin
        if (clr_we) begin
            par_mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be[i]) par_mem[wr_addr][i] <= byte_parity(wr_data[8*i +: 8]) ^ par_inv;
            end
        end
    end

    always_comb begin
        rd_par  = '0;
        rd_perr = 1'b0;
        if (rd_in) begin
            rd_par = par_mem[rd_addr];
            if (same_addr) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (wr_be[i]) rd_par[i] = byte_parity(wr_data[8*i +: 8]) ^ par_inv;
                end
            end
        end
        for (int i = 0; i < BE_W; i++) begin
            if (byte_parity(rd_word[8*i +: 8]) != rd_par[i]) rd_perr = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) parity_err <= 1'b0;
        else      parity_err <= rd_ok && rd_perr;
    end
`endif

endmodule

// File: tb/tb_ram_dp_clr.sv
// Scoreboard bench: a 32-bit x 32 instance and an 8-bit x 20 (non power of two) instance.
module tb_ram_dp_clr;

    typedef struct packed {
        logic [31:0] d;
        logic        p;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        a_wr_en, a_rd_en, a_clr, a_rd_valid, a_busy;
    logic [4:0]  a_wr_addr, a_rd_addr;
    logic [31:0] a_wr_data, a_rd_data;
    logic [3:0]  a_wr_be;
    logic        b_wr_en, b_rd_en, b_clr, b_rd_valid, b_busy;
    logic [4:0]  b_wr_addr, b_rd_addr;
    logic [7:0]  b_wr_data, b_rd_data;
    logic [0:0]  b_wr_be;
`ifdef RAM_PARITY_EN
    logic a_par_inv, a_parity_err, b_par_inv, b_parity_err;
`endif

    ram_dp_clr #(.DATA_W(32), .DEPTH(32)) u_dut_a (
        .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .wr_be(a_wr_be), .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .rd_valid(a_rd_valid), .clr(a_clr), .busy(a_busy)
`ifdef RAM_PARITY_EN
        , .par_inv(a_par_inv), .parity_err(a_parity_err)
`endif
    );

    ram_dp_clr #(.DATA_W(8), .DEPTH(20)) u_dut_b (
        .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .wr_be(b_wr_be), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .rd_valid(b_rd_valid), .clr(b_clr), .busy(b_busy)
`ifdef RAM_PARITY_EN
        , .par_inv(b_par_inv), .parity_err(b_parity_err)
`endif
    );

    int   vectors = 0;
    int   miscompares = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst && a_rd_valid) begin
            if (qa.size() == 0) begin
                check("a_unexpected_valid", {31'b0, a_rd_valid}, 32'd0);
            end else begin
                ea = qa.pop_front();
                check("a_rd_data", a_rd_data, ea.d);
`ifdef RAM_PARITY_EN
                check("a_parity_err", {31'b0, a_parity_err}, {31'b0, ea.p});
`endif
            end
        end
`ifdef RAM_PARITY_EN
        if (rst && !a_rd_valid && a_parity_err) check("a_parity_err_idle", 32'd1, 32'd0);
`endif
    end

    always @(negedge clk) begin
        if (rst && b_rd_valid) begin
            if (qb.size() == 0) begin
                check("b_unexpected_valid", {31'b0, b_rd_valid}, 32'd0);
            end else begin
                eb = qb.pop_front();
                check("b_rd_data", {24'b0, b_rd_data}, eb.d);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] be);
        a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data; a_wr_be = be;
        step();
        a_wr_en = 1'b0;
    endtask

    task automatic a_read(input logic [4:0] addr, input logic [31:0] exp, input logic p);
        qa.push_back('{d: exp, p: p});
        a_rd_en = 1'b1; a_rd_addr = addr;
        step();
        a_rd_en = 1'b0;
    endtask

    task automatic a_collide(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] be, input logic [31:0] exp);
        qa.push_back('{d: exp, p: 1'b0});
        a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data; a_wr_be = be;
        a_rd_en = 1'b1; a_rd_addr = addr;
        step();
        a_wr_en = 1'b0; a_rd_en = 1'b0;
    endtask

    task automatic b_write(input logic [4:0] addr, input logic [7:0] data);
        b_wr_en = 1'b1; b_wr_addr = addr; b_wr_data = data; b_wr_be = 1'b1;
        step();
        b_wr_en = 1'b0;
    endtask

    task automatic b_read(input logic [4:0] addr, input logic [7:0] exp);
        qb.push_back('{d: {24'b0, exp}, p: 1'b0});
        b_rd_en = 1'b1; b_rd_addr = addr;
        step();
        b_rd_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int na, nb, n;
        a_wr_en = 0; a_rd_en = 0; a_clr = 0; a_wr_addr = 0; a_rd_addr = 0; a_wr_data = 0; a_wr_be = 0;
        b_wr_en = 0; b_rd_en = 0; b_clr = 0; b_wr_addr = 0; b_rd_addr = 0; b_wr_data = 0; b_wr_be = 0;
`ifdef RAM_PARITY_EN
        a_par_inv = 0; b_par_inv = 0;
`endif
        repeat (3) step();
        check("reset_a_busy", {31'b0, a_busy}, 32'd1);
        check("reset_a_rd_valid", {31'b0, a_rd_valid}, 32'd0);
        check("reset_a_rd_data", a_rd_data, 32'd0);
        check("reset_b_busy", {31'b0, b_busy}, 32'd1);

        // Sweep after reset release: DEPTH busy cycles on each instance
        rst = 1'b1;
        na = 0; nb = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_busy) na++;
            if (b_busy) nb++;
        end
        check("a_reset_sweep_cycles", 32'(na), 32'd32);
        check("b_reset_sweep_cycles", 32'(nb), 32'd20);
        step();
        a_read(5'd5, 32'h0, 1'b0);

        // Byte enables and write-first collisions
        a_write(5'd3, 32'h11223344, 4'b1111);
        a_write(5'd3, 32'hAABBCCDD, 4'b0101);
        a_read(5'd3, 32'h11BB33DD, 1'b0);
        a_collide(5'd7, 32'h0000005A, 4'b1111, 32'h0000005A);
        a_write(5'd9, 32'h11223344, 4'b1111);
        a_collide(5'd9, 32'hAABBCCDD, 4'b0101, 32'h11BB33DD);
        a_read(5'd9, 32'h11BB33DD, 1'b0);
        a_read(5'd20, 32'h0, 1'b0);

        // Fill, then clr with writes, reads and a repeated clr during the sweep
        for (int i = 0; i < 32; i++) a_write(5'(i), 32'hA5000000 | 32'(i), 4'b1111);
        a_read(5'd31, 32'hA500001F, 1'b0);
        a_read(5'd0, 32'hA5000000, 1'b0);
        step();
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'hFFFFFFFF; a_wr_be = 4'b1111;
        a_rd_en = 1'b1; a_rd_addr = 5'd0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!a_busy) break;
            n++;
            if (n == 10) a_clr = 1'b1;
            if (n == 11) a_clr = 1'b0;
        end
        a_wr_en = 1'b0; a_rd_en = 1'b0; a_clr = 1'b0;
        check("a_clr_sweep_cycles", 32'(n), 32'd32);
        step();
        for (int i = 0; i < 32; i++) a_read(5'(i), 32'h0, 1'b0);

        // Non power-of-two depth: out-of-range accesses
        b_write(5'd19, 8'h3C);
        b_write(5'd25, 8'h77);
        b_read(5'd25, 8'h00);
        b_read(5'd19, 8'h3C);
        b_read(5'd5, 8'h00);
        b_read(5'd9, 8'h00);

`ifdef RAM_PARITY_EN
        a_par_inv = 1'b1;
        a_write(5'd2, 32'h0000000F, 4'b0001);
        a_par_inv = 1'b0;
        a_read(5'd2, 32'h0000000F, 1'b1);
        a_write(5'd2, 32'h0000000F, 4'b0001);
        a_read(5'd2, 32'h0000000F, 1'b0);
`endif

        repeat (3) step();
        check("a_queue_drained", 32'(qa.size()), 32'd0);
        check("b_queue_drained", 32'(qb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
